// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   Single-clock FIFO controller that uses an external dual-port RAM
//   (synchronous read, 1-clock latency) as its storage array. A 2-entry
//   output queue hides the RAM read latency, which gives one word per clock
//   in each direction when the stream is sustained.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wr_valid/wr_ready   write stream handshake, wr_data is the write word
//   rd_valid/rd_ready   read stream handshake, rd_data is the head word
//   level               words held: RAM + in-flight fetch + output queue
//   full, empty         RAM at capacity / nothing held anywhere
//   ram_we, ram_write_addr, ram_data_in   RAM write port
//   ram_read_addr, ram_data_out           RAM read port
module ram_fifo_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W+1:0] level,
  output logic              full,
  output logic              empty,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_count_q, mem_count_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        out_count_q, out_count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic       accept;
  logic       pop;
  logic       fetch;
  logic [2:0] occ_after;

  // Handshakes and fetch decision
  always_comb begin
    wr_ready  = (mem_count_q < DEPTH_C) && rst_n;
    accept    = wr_valid && wr_ready;
    pop       = (out_count_q != 2'd0) && rd_ready;
    // Slots the output queue will need after this cycle's pop; a fetch is
    // only launched if its data is guaranteed a free slot when it lands.
    occ_after = {1'b0, out_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    fetch     = (mem_count_q != '0) && (occ_after < 3'd2);
  end

  // Pointer, occupancy and output-queue next state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    inflight_d  = fetch;
    out_count_d = out_count_q;
    head_d      = head_q;
    tail_d      = tail_q;

    if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (fetch)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    // Accept and fetch together leave the RAM occupancy unchanged.
    unique case ({accept, fetch})
      2'b10:   mem_count_d = mem_count_q + CNT_ONE;
      2'b01:   mem_count_d = mem_count_q - CNT_ONE;
      default: ;
    endcase

    // Capture of the RAM word (inflight_q) against a consumer pop.
    unique case ({inflight_q, pop})
      2'b10: begin
        if (out_count_q == 2'd0) head_d = ram_data_out;
        else                     tail_d = ram_data_out;
        out_count_d = out_count_q + 2'd1;
      end
      2'b01: begin
        head_d      = tail_q;
        out_count_d = out_count_q - 2'd1;
      end
      2'b11: begin
        if (out_count_q == 2'd1) begin
          head_d = ram_data_out;
        end else begin
          head_d = tail_q;
          tail_d = ram_data_out;
        end
      end
      default: ;
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
      out_count_q <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
      out_count_q <= out_count_d;
    end
  end

  // Output-queue storage; contents are qualified by out_count_q
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  // Outputs
  always_comb begin
    rd_valid       = (out_count_q != 2'd0);
    rd_data        = head_q;
    level          = {1'b0, mem_count_q}
                   + {{(ADDR_W+1){1'b0}}, inflight_q}
                   + {{ADDR_W{1'b0}}, out_count_q};
    full           = (mem_count_q == DEPTH_C);
    empty          = (level == '0);
    ram_we         = accept;
    ram_write_addr = wr_ptr_q;
    ram_data_in    = wr_data;
    ram_read_addr  = rd_ptr_q;
  end

endmodule
